// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bundle for reg_scoreboard.
// The optional stall_cycles signal exists only when SCOREBOARD_STATS_EN is defined.
interface reg_scoreboard_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
);
  logic                issue_valid;
  logic                issue_wr;
  logic [ADDR_W-1:0]   issue_rd;
  logic                rn_use;
  logic [ADDR_W-1:0]   rn_addr;
  logic                rm_use;
  logic [ADDR_W-1:0]   rm_addr;
  logic                wb_valid;
  logic [ADDR_W-1:0]   wb_rd;
  logic                flush;
  logic                stall;
  logic [NUM_REGS-1:0] busy_vec;
  logic                underflow_err;
`ifdef SCOREBOARD_STATS_EN
  logic [15:0]         stall_cycles;

  modport master (
    output issue_valid, issue_wr, issue_rd, rn_use, rn_addr, rm_use, rm_addr,
    output wb_valid, wb_rd, flush,
    input  stall, busy_vec, underflow_err, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_wr, issue_rd, rn_use, rn_addr, rm_use, rm_addr,
    input  wb_valid, wb_rd, flush,
    output stall, busy_vec, underflow_err, stall_cycles
  );
`else
  modport master (
    output issue_valid, issue_wr, issue_rd, rn_use, rn_addr, rm_use, rm_addr,
    output wb_valid, wb_rd, flush,
    input  stall, busy_vec, underflow_err
  );

  modport slave (
    input  issue_valid, issue_wr, issue_rd, rn_use, rn_addr, rm_use, rm_addr,
    input  wb_valid, wb_rd, flush,
    output stall, busy_vec, underflow_err
  );
`endif
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters between decode and writeback.
// Optional stall statistics counter enabled by defining SCOREBOARD_STATS_EN.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned ZERO_REG = 31
) (
  input logic            clk,
  input logic            reset,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0]  CntMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [CNT_W-1:0]    count_q [NUM_REGS];
  logic [CNT_W-1:0]    count_d [NUM_REGS];
  logic                underflow_q, underflow_d;
  logic [NUM_REGS-1:0] busy_eff;
  logic [NUM_REGS-1:0] busy_vec;
  logic                hazard_rn, hazard_rm, hazard_full;
  logic                stall;
  logic                issue_acc;

  // Effective busy per register, with same-cycle writeback bypass on the last pending write.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      busy_eff[i] = (count_q[i] != '0) &&
                    !(sb.wb_valid && (sb.wb_rd == ADDR_W'(i)) && (count_q[i] == CntOne));
      busy_vec[i] = (count_q[i] != '0);
    end
    busy_eff[ZERO_REG] = 1'b0;
    busy_vec[ZERO_REG] = 1'b0;
  end

  // Stall on source hazards or when the destination counter would overflow.
  always_comb begin
    hazard_rn   = sb.rn_use && busy_eff[sb.rn_addr];
    hazard_rm   = sb.rm_use && busy_eff[sb.rm_addr];
    hazard_full = sb.issue_wr && (count_q[sb.issue_rd] == CntMax) &&
                  !(sb.wb_valid && (sb.wb_rd == sb.issue_rd));
    stall       = sb.issue_valid && (hazard_rn || hazard_rm || hazard_full);
    issue_acc   = sb.issue_valid && sb.issue_wr && !stall && (sb.issue_rd != ZeroAddr);
  end

  // Next counter values; flush discards everything, simultaneous inc/dec cancel.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      logic inc, dec;
      inc = issue_acc && (sb.issue_rd == ADDR_W'(i));
      dec = sb.wb_valid && (sb.wb_rd == ADDR_W'(i)) && (count_q[i] != '0);
      count_d[i] = count_q[i];
      if (sb.flush) begin
        count_d[i] = '0;
      end else if (inc && !dec) begin
        count_d[i] = count_q[i] + CntOne;
      end else if (dec && !inc) begin
        count_d[i] = count_q[i] - CntOne;
      end
    end
    // Sticky error: retiring a write that was never issued (flush suppresses the retire).
    underflow_d = underflow_q ||
                  (!sb.flush && sb.wb_valid && (sb.wb_rd != ZeroAddr) &&
                   (count_q[sb.wb_rd] == '0));
  end

  // Counter and error state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        count_q[i] <= '0;
      end
      underflow_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        count_q[i] <= count_d[i];
      end
      underflow_q <= underflow_d;
    end
  end

  assign sb.stall         = stall;
  assign sb.busy_vec      = busy_vec;
  assign sb.underflow_err = underflow_q;

`ifdef SCOREBOARD_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of stalled cycles; only reset clears it.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // Statistics register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign sb.stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight writes to the 32 architectural registers between decode and writeback.
- Consumes the 5-bit destination-register fields carried through the pipeline registers.
- Decode side issues destination registers; writeback side retires them.
- Asserts stall when a decode-stage source operand, or a destination register whose counter is full, still has writes pending.

Parameters:
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W == NUM_REGS.
- CNT_W, 2, width of each per-register pending-write counter; max pending = 2**CNT_W-1.
- ZERO_REG, 31, hardwired-zero register; never tracked, never busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_wr  in  1  the instruction writes a register.
- issue_rd  in  ADDR_W  destination register of the issuing instruction.
- rn_use  in  1  first source operand is read.
- rn_addr  in  ADDR_W  first source register.
- rm_use  in  1  second source operand is read.
- rm_addr  in  ADDR_W  second source register.
- wb_valid  in  1  writeback retires a register write this cycle.
- wb_rd  in  ADDR_W  register being retired.
- flush  in  1  discard all pending writes (branch mispredict).
- stall  out  1  combinational; decode must hold its instruction.
- busy_vec  out  NUM_REGS  registered; bit i = 1 when count[i] != 0.
- underflow_err  out  1  registered, sticky; a writeback retired a register with count 0.

Behaviour:
- State:
  - count[i], CNT_W bits, one per register.
  - underflow_err flag.
- Reset (reset==0 at a clk edge):
  - all count = 0, so busy_vec = 0.
  - underflow_err = 0.
  - reset overrides flush, issue and wb.
- Effective busy of register r, used for stall:
  - busy_eff(r) = (count[r] != 0) and not (wb_valid and wb_rd==r and count[r]==1).
  - This is a same-cycle writeback bypass.
  - r==ZERO_REG is never busy.
- stall = issue_valid and (A or B or C):
  - A: rn_use and busy_eff(rn_addr).
  - B: rm_use and busy_eff(rm_addr).
  - C: issue_wr and count[issue_rd] == max and not (wb_valid and wb_rd==issue_rd).
  - Condition C prevents counter overflow.
- Accepted issue: issue_valid and issue_wr and not stall and issue_rd != ZERO_REG.
- Counter update per register i, when not flush and not reset:
  - +1 if accepted issue targets i.
  - -1 if wb_valid and wb_rd==i and count[i]!=0.
  - Both in the same cycle: count unchanged.
- Writeback to a register with count 0:
  - count stays 0.
  - underflow_err set to 1 next cycle; it holds until reset.
- Writeback to ZERO_REG: ignored; no error.
- flush (reset==1):
  - all count = 0 next cycle.
  - overrides same-cycle issue and wb.
  - stall still computed from current state that cycle.
  - underflow_err unaffected.
- Latency:
  - issue to busy visible at the next cycle's stall: 1 cycle.
  - wb clears the hazard in the same cycle via the bypass.
- busy_vec reflects count after the edge; bit ZERO_REG is always 0.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- When defined:
  - Extra output stall_cycles, 16 bits, registered.
  - Increments each cycle stall==1.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- When undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- RAW hazard:
  - Cycle 0: reset=0; then reset=1.
  - Issue issue_wr=1, issue_rd=5.
  - Next cycle: rn_use=1, rn_addr=5, issue_valid=1 -> stall=1, busy_vec[5]=1.
  - Assert wb_valid=1, wb_rd=5 in that cycle -> stall=0 (bypass); busy_vec[5]=0 next cycle.
- WAW count and overflow (CNT_W=2):
  - Issue rd=7 three times without wb -> count[7]=3.
  - Fourth issue to rd=7 -> stall=1.
  - Same-cycle wb_rd=7 -> stall=0, count stays 3.
- Zero register:
  - Issue rd=31 -> busy_vec=0.
  - rn_addr=31 -> stall=0.
  - wb_rd=31 with count 0 -> underflow_err stays 0.
- Flush:
  - Registers 2, 9 and 20 pending.
  - flush=1 with simultaneous issue rd=3 -> busy_vec=0 next cycle.
- Underflow:
  - wb_valid=1, wb_rd=12 with count 0 -> underflow_err=1 next cycle.
  - Remains 1 through flush; cleared only by reset=0.
- Reset mid-operation:
  - 3 registers pending, reset=0 for one cycle -> busy_vec=0, stall=0, underflow_err=0.
  - Stats build: stall_cycles=0 after reset, and counts exactly 4 after 4 stalled cycles.
